hazard_forward_unit: RTL and testbench

//  Parametrised hazard/forward controller for the 5-stage core (F/D/E/M/W).
//  - Generates per-operand forwarding selects for NUM_SRC E-stage operands, M over W.
//  - Detects load-use hazards; handles branch flushes.
//  - Runs an FSM that freezes F/D/E while a multi-cycle E-stage op (MAC/mul) completes.

---
 rtl/hazard_forward_unit_if.sv | 51 +++++
 rtl/hazard_forward_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hazard_forward_unit_if : pipeline-side bundle for the hazard unit      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface hazard_forward_unit_if #(
  parameter int NUM_SRC  = 3,
  parameter int REG_AW   = 4,
  parameter int MC_LEN_W = 4
);
  logic [NUM_SRC*REG_AW-1:0] RAE;
  logic [NUM_SRC*REG_AW-1:0] RAD;
  logic [NUM_SRC-1:0]        RAValidD;
  logic [REG_AW-1:0]         WA3E;
  logic [REG_AW-1:0]         WA3M;
  logic [REG_AW-1:0]         WA3W;
  logic                      RegWriteE;
  logic                      RegWriteM;
  logic                      RegWriteW;
  logic                      MemtoRegE;
  logic                      BranchTakenE;
  logic                      McStartE;
  logic [MC_LEN_W-1:0]       McLenE;
  logic [NUM_SRC*2-1:0]      FwdSel;
  logic                      StallF;
  logic                      StallD;
  logic                      StallE;
  logic                      FlushD;
  logic                      FlushE;
  logic                      FlushM;
  logic                      McBusy;
  logic                      McDone;
  logic [31:0]               StallCount;

  modport master (
    output RAE, RAD, RAValidD, WA3E, WA3M, WA3W,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE,
    output McStartE, McLenE,
    input  FwdSel, StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  McBusy, McDone, StallCount
  );

  modport slave (
    input  RAE, RAD, RAValidD, WA3E, WA3M, WA3W,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, BranchTakenE,
    input  McStartE, McLenE,
    output FwdSel, StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output McBusy, McDone, StallCount
  );
endinterface
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | hazard_forward_unit : forwarding, load-use and multi-cycle stall ctrl  |
// | Optional stall counter enabled by macro HAZ_STALL_CNT_EN. Rev 1.0     |
// +-----------------------------------------------------------------------+
module hazard_forward_unit #(
  parameter int NUM_SRC     = 3,
  parameter int REG_AW      = 4,
  parameter int NO_FWD_ADDR = 15,
  parameter int MC_LEN_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_forward_unit_if.slave  hz
);

  // One extra bit lets NO_FWD_ADDR = 2**REG_AW match no real address.
  localparam logic [REG_AW:0]     NO_FWD  = NO_FWD_ADDR[REG_AW:0];
  localparam logic [MC_LEN_W-1:0] LEN_ONE = MC_LEN_W'(1);
  localparam logic [MC_LEN_W-1:0] LEN_TWO = MC_LEN_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_t;

  mc_state_t           state_q;
  logic [MC_LEN_W-1:0] cnt_q;
  logic                mc_busy_q;
  logic                mc_done_q;

  logic [NUM_SRC-1:0]  w_lu_hit;
  logic                w_mc_stall;
  logic                w_lu;
  logic                w_wa3e_nofwd;

  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_AW-1:0] w_rae;
      logic [REG_AW-1:0] w_rad;
      logic              w_no_fwd;
      logic              w_hit_m;
      logic              w_hit_w;

      assign w_rae    = hz.RAE[i*REG_AW +: REG_AW];
      assign w_rad    = hz.RAD[i*REG_AW +: REG_AW];
      assign w_no_fwd = ({1'b0, w_rae} == NO_FWD);
      assign w_hit_m  = (w_rae == hz.WA3M) && hz.RegWriteM && !w_no_fwd;
      assign w_hit_w  = (w_rae == hz.WA3W) && hz.RegWriteW && !w_no_fwd;

      assign hz.FwdSel[2*i +: 2] = w_hit_m ? 2'b10 : (w_hit_w ? 2'b01 : 2'b00);
      assign w_lu_hit[i]         = hz.RAValidD[i] && (w_rad == hz.WA3E);
    end
  endgenerate

  assign w_wa3e_nofwd = ({1'b0, hz.WA3E} == NO_FWD);

  // Start cycle stalls directly from the inputs; the FSM only tracks the rest.
  assign w_mc_stall = ((state_q == ST_IDLE) && hz.McStartE && (hz.McLenE > LEN_ONE))
                    || (state_q == ST_BUSY);

  assign w_lu = hz.MemtoRegE && hz.RegWriteE && (|w_lu_hit) && !w_wa3e_nofwd
             && !hz.BranchTakenE && !w_mc_stall;

  assign hz.StallF = w_lu || w_mc_stall;
  assign hz.StallD = w_lu || w_mc_stall;
  assign hz.StallE = w_mc_stall;
  assign hz.FlushD = hz.BranchTakenE && !w_mc_stall;
  assign hz.FlushE = (w_lu || hz.BranchTakenE) && !w_mc_stall;
  assign hz.FlushM = w_mc_stall;
  assign hz.McBusy = mc_busy_q;
  assign hz.McDone = mc_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mc_busy_q <= 1'b0;
      mc_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hz.McStartE && (hz.McLenE > LEN_TWO)) begin
            state_q   <= ST_BUSY;
            cnt_q     <= hz.McLenE - LEN_TWO;
            mc_busy_q <= 1'b1;
          end else if (hz.McStartE && (hz.McLenE == LEN_TWO)) begin
            state_q   <= ST_DONE;
            mc_busy_q <= 1'b1;
            mc_done_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt_q == LEN_ONE) begin
            state_q   <= ST_DONE;
            mc_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - LEN_ONE;
          end
        end
        // The op is still in E here, so a held McStartE must not retrigger.
        ST_DONE: begin
          state_q   <= ST_IDLE;
          mc_busy_q <= 1'b0;
          mc_done_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          mc_busy_q <= 1'b0;
          mc_done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hz.StallF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.StallCount = stall_cnt_q;
`else
  assign hz.StallCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_hazard_forward_unit : scoreboard bench for hazard_forward_unit      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_hazard_forward_unit;

  localparam int NUM_SRC  = 3;
  localparam int REG_AW   = 4;
  localparam int MC_LEN_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .MC_LEN_W(MC_LEN_W)) bus ();

  hazard_forward_unit #(
    .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .NO_FWD_ADDR(15), .MC_LEN_W(MC_LEN_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (bus.slave)
  );

  typedef struct {
    logic [5:0]  fwd;
    logic        sf, se, fd, fe, fm, busy, done;
    logic [31:0] scnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] tb_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic [5:0] fwd, input logic sf, input logic se,
                            input logic fd, input logic fe, input logic fm,
                            input logic busy, input logic done);
    exp_t e;
    e.fwd = fwd; e.sf = sf; e.se = se; e.fd = fd; e.fe = fe; e.fm = fm;
    e.busy = busy; e.done = done; e.scnt = tb_cnt;
`ifdef HAZ_STALL_CNT_EN
    if (sf && tb_cnt != 32'hFFFF_FFFF) tb_cnt = tb_cnt + 32'd1;
`endif
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("FwdSel",     32'(bus.FwdSel), 32'(e.fwd));
    chk("StallF",     32'(bus.StallF), 32'(e.sf));
    chk("StallD",     32'(bus.StallD), 32'(e.sf));
    chk("StallE",     32'(bus.StallE), 32'(e.se));
    chk("FlushD",     32'(bus.FlushD), 32'(e.fd));
    chk("FlushE",     32'(bus.FlushE), 32'(e.fe));
    chk("FlushM",     32'(bus.FlushM), 32'(e.fm));
    chk("McBusy",     32'(bus.McBusy), 32'(e.busy));
    chk("McDone",     32'(bus.McDone), 32'(e.done));
    chk("StallCount", bus.StallCount,  e.scnt);
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.RAE = {4'd7, 4'd7, 4'd7};  bus.RAD = {4'd7, 4'd7, 4'd7};
    bus.RAValidD = '0;
    bus.WA3E = '0; bus.WA3M = '0; bus.WA3W = '0;
    bus.RegWriteE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
    bus.MemtoRegE = 0; bus.BranchTakenE = 0;
    bus.McStartE = 0; bus.McLenE = '0;
  endtask

  task automatic expect_quiet();
    expect_out(6'b0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mc_op(input logic [MC_LEN_W-1:0] len, input int n_stall);
    bus.McStartE = 1; bus.McLenE = len;
    for (int k = 0; k < n_stall; k++) begin
      expect_out(6'b0, 1, 1, 0, 0, 1, (k != 0), 0);
      step();
      bus.McLenE = 4'd15;  // later changes must be ignored
    end
    expect_out(6'b0, 0, 0, 0, 0, 0, 1, 1);
    step();
    idle_inputs();
    expect_quiet();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    #12;
    expect_quiet();
    compare();
    @(posedge clk); #1;
    rst_n = 1;

    // Forwarding: M over W, W alone, never-forward address, multiple operands
    bus.RAE = {4'd7, 4'd7, 4'd3}; bus.WA3M = 3; bus.RegWriteM = 1; bus.WA3W = 3; bus.RegWriteW = 1;
    expect_out(6'b000010, 0, 0, 0, 0, 0, 0, 0); step();
    bus.RegWriteM = 0;
    expect_out(6'b000001, 0, 0, 0, 0, 0, 0, 0); step();
    bus.RegWriteM = 1; bus.RAE = {4'd7, 4'd7, 4'd15}; bus.WA3M = 15; bus.WA3W = 15;
    expect_out(6'b000000, 0, 0, 0, 0, 0, 0, 0); step();
    bus.RAE = {4'd9, 4'd4, 4'd1}; bus.WA3M = 4; bus.WA3W = 9;
    expect_out(6'b011000, 0, 0, 0, 0, 0, 0, 0); step();
    bus.RegWriteW = 0;
    expect_out(6'b001000, 0, 0, 0, 0, 0, 0, 0); step();
    idle_inputs();

    // Load-use
    bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.WA3E = 5;
    bus.RAD = {4'd7, 4'd5, 4'd7}; bus.RAValidD = 3'b010;
    expect_out(6'b0, 1, 0, 0, 1, 0, 0, 0); step();
    bus.RAValidD = 3'b000;
    expect_quiet(); step();
    bus.RAD = {4'd5, 4'd7, 4'd7}; bus.RAValidD = 3'b100;
    expect_out(6'b0, 1, 0, 0, 1, 0, 0, 0); step();
    bus.RegWriteE = 0;
    expect_quiet(); step();
    bus.RegWriteE = 1; bus.WA3E = 15; bus.RAD = {4'd7, 4'd15, 4'd7}; bus.RAValidD = 3'b010;
    expect_quiet(); step();
    bus.WA3E = 5; bus.RAD = {4'd7, 4'd5, 4'd7}; bus.BranchTakenE = 1;
    expect_out(6'b0, 0, 0, 1, 1, 0, 0, 0); step();
    idle_inputs();

    // Multi-cycle lengths 4, 0, 1, 2
    mc_op(4'd4, 3);
    bus.McStartE = 1; bus.McLenE = 4'd0;
    expect_quiet(); step();
    bus.McLenE = 4'd1;
    expect_quiet(); step();
    idle_inputs();
    expect_quiet(); step();
    mc_op(4'd2, 1);
    mc_op(4'd3, 2);

    // Branch together with mc start: flush deferred to DONE
    bus.McStartE = 1; bus.McLenE = 4'd2; bus.BranchTakenE = 1;
    expect_out(6'b0, 1, 1, 0, 0, 1, 0, 0); step();
    expect_out(6'b0, 0, 0, 1, 1, 0, 1, 1); step();
    idle_inputs();
    expect_quiet(); step();

    // Reset in third stall cycle of a 9-cycle op
    bus.McStartE = 1; bus.McLenE = 4'd9;
    expect_out(6'b0, 1, 1, 0, 0, 1, 0, 0); step();
    expect_out(6'b0, 1, 1, 0, 0, 1, 1, 0); step();
    expect_out(6'b0, 1, 1, 0, 0, 1, 1, 0);
    @(negedge clk);
    compare();
    #2;
    rst_n = 0; bus.McStartE = 0;
    tb_cnt = '0;
    #1;
    expect_quiet();
    compare();
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      expect_quiet(); step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
